// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO control slice: register indices,
// default pin count and the bus-response FSM states.
package gpio_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [2:0] ADDR_EN      = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_OUT     = 3'd2;
  localparam logic [2:0] ADDR_IN      = 3'd3;
  localparam logic [2:0] ADDR_IE_MASK = 3'd4;
  localparam logic [2:0] ADDR_EDGE    = 3'd5;
  localparam logic [2:0] ADDR_STATUS  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-pin input synchroniser chain followed by a delay flop, giving the
// synchronised value and single-cycle rise/fall strobes.
module gpio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      sync_d <= '0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      sync_d <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~sync_d;
  assign fall = ~sync & sync_d;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO control/status register block: bus register port with a one-cycle
// read response, pin configuration registers and a maskable edge interrupt.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_valid,
  output logic             bus_ready,
  input  logic             bus_we,
  input  logic [2:0]       bus_addr,
  input  logic [WIDTH-1:0] bus_wdata,
  output logic             bus_rvalid,
  output logic [WIDTH-1:0] bus_rdata,
  output logic [WIDTH-1:0] gpio_en,
  output logic [WIDTH-1:0] gpio_dir,
  output logic [WIDTH-1:0] gpio_out,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  // Handshake: a request transfers on a rising edge where bus_valid and
  // bus_ready are both 1; the response (bus_rvalid) follows on the next cycle.

  state_t           state;
  logic             ready_q;
  logic             rvalid_q;
  logic [WIDTH-1:0] rdata_q;
  logic             irq_q;

  logic [WIDTH-1:0] en_q, dir_q, out_q, ie_q, edge_q, status_q;
  logic [WIDTH-1:0] sync, rise, fall;
  logic [WIDTH-1:0] evt, w1c_mask, rd_val;
  logic             accept, wr;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (gpio_in),
    .sync (sync),
    .rise (rise),
    .fall (fall)
  );

  assign accept = bus_valid & ready_q;
  assign wr     = accept & bus_we;

  // Only enabled input pins can flag an event, in the direction EDGE selects.
  assign evt      = en_q & dir_q & ((edge_q & rise) | (~edge_q & fall));
  assign w1c_mask = (wr && bus_addr == ADDR_STATUS) ? bus_wdata : '0;

  always_comb begin
    rd_val = '0;
    case (bus_addr)
      ADDR_EN:      rd_val = en_q;
      ADDR_DIR:     rd_val = dir_q;
      ADDR_OUT:     rd_val = out_q;
      ADDR_IN:      rd_val = sync;
      ADDR_IE_MASK: rd_val = ie_q;
      ADDR_EDGE:    rd_val = edge_q;
      ADDR_STATUS:  rd_val = status_q;
      default:      rd_val = '0;
    endcase
  end

  // Bus response FSM; ready stays low through reset and every RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_RESP;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b1;
            rdata_q  <= bus_we ? '0 : rd_val;
          end else begin
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
          end
        end
        ST_RESP: begin
          state    <= ST_IDLE;
          ready_q  <= 1'b1;
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
        end
        default: begin
          state    <= ST_IDLE;
          ready_q  <= 1'b0;
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q   <= '0;
      dir_q  <= '0;
      out_q  <= '0;
      ie_q   <= '0;
      edge_q <= '0;
    end else if (wr) begin
      case (bus_addr)
        ADDR_EN:      en_q   <= bus_wdata;
        ADDR_DIR:     dir_q  <= bus_wdata;
        ADDR_OUT:     out_q  <= bus_wdata;
        ADDR_IE_MASK: ie_q   <= bus_wdata;
        ADDR_EDGE:    edge_q <= bus_wdata;
        default:      ;
      endcase
    end
  end

  // A new event wins over a same-cycle clear of that bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= (status_q & ~w1c_mask) | evt;
      irq_q    <= |(status_q & ie_q);
    end
  end

  assign bus_ready  = ready_q;
  assign bus_rvalid = rvalid_q;
  assign bus_rdata  = rdata_q;
  assign gpio_en    = en_q;
  assign gpio_dir   = dir_q;
  assign gpio_out   = out_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: register table plus hand-timed sequences
// for synchronisation, interrupts, set/clear collision and reset mid-response.
module tb_gpio_ctrl;
  import gpio_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         bus_valid;
  logic         bus_ready;
  logic         bus_we;
  logic [2:0]   bus_addr;
  logic [W-1:0] bus_wdata;
  logic         bus_rvalid;
  logic [W-1:0] bus_rdata;
  logic [W-1:0] gpio_en, gpio_dir, gpio_out, gpio_in;
  logic         irq;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         we;
    logic [2:0]   addr;
    logic [W-1:0] wdata;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl [14];

  gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .gpio_en    (gpio_en),
    .gpio_dir   (gpio_dir),
    .gpio_out   (gpio_out),
    .gpio_in    (gpio_in),
    .irq        (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge inside the response cycle.
  task automatic xfer(input logic we, input logic [2:0] addr,
                      input logic [W-1:0] wdata, input logic [W-1:0] exp);
    int n;
    logic [W-1:0] e;
    exp_q.push_back(we ? '0 : exp);
    bus_valid = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    n = 0;
    while (!bus_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      e = exp_q.pop_back();
      bus_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    check("resp_rvalid", 32'(bus_rvalid), 32'd1);
    check("resp_ready", 32'(bus_ready), 32'd0);
    e = exp_q.pop_front();
    check(we ? "wr_rdata" : "rd_rdata", 32'(bus_rdata), 32'(e));
  endtask

  initial begin
    tbl[0]  = '{1'b1, ADDR_EN,      8'hF0, 8'h00};
    tbl[1]  = '{1'b1, ADDR_DIR,     8'h0F, 8'h00};
    tbl[2]  = '{1'b1, ADDR_OUT,     8'hA5, 8'h00};
    tbl[3]  = '{1'b0, ADDR_EN,      8'h00, 8'hF0};
    tbl[4]  = '{1'b0, ADDR_DIR,     8'h00, 8'h0F};
    tbl[5]  = '{1'b0, ADDR_OUT,     8'h00, 8'hA5};
    tbl[6]  = '{1'b1, ADDR_IE_MASK, 8'h5A, 8'h00};
    tbl[7]  = '{1'b0, ADDR_IE_MASK, 8'h00, 8'h5A};
    tbl[8]  = '{1'b1, ADDR_EDGE,    8'hC3, 8'h00};
    tbl[9]  = '{1'b0, ADDR_EDGE,    8'h00, 8'hC3};
    tbl[10] = '{1'b0, ADDR_STATUS,  8'h00, 8'h00};
    tbl[11] = '{1'b1, 3'd7,         8'hFF, 8'h00};
    tbl[12] = '{1'b0, 3'd7,         8'h00, 8'h00};
    tbl[13] = '{1'b0, ADDR_IN,      8'h00, 8'h00};

    rst = 1'b0; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0;
    bus_wdata = '0; gpio_in = '0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus_ready), 32'd0);
    check("rst_rvalid", 32'(bus_rvalid), 32'd0);
    check("rst_rdata", 32'(bus_rdata), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus_ready), 32'd1);
    check("post_rst_en", 32'(gpio_en), 32'd0);
    check("post_rst_dir", 32'(gpio_dir), 32'd0);
    check("post_rst_out", 32'(gpio_out), 32'd0);
    check("post_rst_rvalid", 32'(bus_rvalid), 32'd0);
    check("post_rst_irq", 32'(irq), 32'd0);

    // register table
    for (int i = 0; i < 14; i++) begin
      xfer(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);
      if (tbl[i].we && tbl[i].addr == ADDR_EN)  check("gpio_en_upd", 32'(gpio_en), 32'(tbl[i].wdata));
      if (tbl[i].we && tbl[i].addr == ADDR_DIR) check("gpio_dir_upd", 32'(gpio_dir), 32'(tbl[i].wdata));
      if (tbl[i].we && tbl[i].addr == ADDR_OUT) check("gpio_out_upd", 32'(gpio_out), 32'(tbl[i].wdata));
    end
    check("irq_after_table", 32'(irq), 32'd0);

    // input synchronisation
    xfer(1'b1, ADDR_IE_MASK, 8'h00, 8'h00);
    xfer(1'b1, ADDR_EDGE,    8'h00, 8'h00);
    xfer(1'b1, ADDR_EN,      8'hFF, 8'h00);
    xfer(1'b1, ADDR_DIR,     8'hFF, 8'h00);
    @(negedge clk);
    gpio_in = 8'h3C;
    xfer(1'b0, ADDR_IN, 8'h00, 8'h00);
    xfer(1'b0, ADDR_IN, 8'h00, 8'h3C);
    xfer(1'b1, ADDR_EN, 8'h00, 8'h00);
    gpio_in = 8'h00;
    idle(5);
    xfer(1'b1, ADDR_STATUS, 8'hFF, 8'h00);
    xfer(1'b0, ADDR_STATUS, 8'h00, 8'h00);

    // rising-edge interrupt on pin 0
    xfer(1'b1, ADDR_IE_MASK, 8'h01, 8'h00);
    xfer(1'b1, ADDR_EDGE,    8'h01, 8'h00);
    xfer(1'b1, ADDR_DIR,     8'h01, 8'h00);
    xfer(1'b1, ADDR_EN,      8'h01, 8'h00);
    @(negedge clk);
    gpio_in = 8'h01;
    idle(2);
    xfer(1'b0, ADDR_STATUS, 8'h00, 8'h00);
    check("irq_before_status", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_raised", 32'(irq), 32'd1);
    xfer(1'b0, ADDR_STATUS, 8'h00, 8'h01);
    xfer(1'b1, ADDR_STATUS, 8'h01, 8'h00);
    check("irq_lag_after_w1c", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_cleared", 32'(irq), 32'd0);

    // direction and mask gating on pin 1 (falling edge)
    xfer(1'b1, ADDR_EDGE, 8'h00, 8'h00);
    xfer(1'b1, ADDR_DIR,  8'h01, 8'h00);
    xfer(1'b1, ADDR_EN,   8'h03, 8'h00);
    gpio_in = 8'h03;
    idle(5);
    gpio_in = 8'h01;
    idle(5);
    xfer(1'b0, ADDR_STATUS, 8'h00, 8'h00);
    xfer(1'b1, ADDR_DIR, 8'h03, 8'h00);
    gpio_in = 8'h03;
    idle(5);
    gpio_in = 8'h01;
    idle(5);
    xfer(1'b0, ADDR_STATUS, 8'h00, 8'h02);
    check("irq_masked", 32'(irq), 32'd0);
    xfer(1'b1, ADDR_STATUS, 8'h02, 8'h00);

    // set-vs-clear collision on pin 0
    xfer(1'b1, ADDR_EDGE, 8'h01, 8'h00);
    gpio_in = 8'h00;
    idle(5);
    gpio_in = 8'h01;
    idle(2);
    xfer(1'b1, ADDR_STATUS, 8'h01, 8'h00);
    xfer(1'b0, ADDR_STATUS, 8'h00, 8'h01);
    xfer(1'b1, ADDR_STATUS, 8'h01, 8'h00);
    xfer(1'b0, ADDR_STATUS, 8'h00, 8'h00);

    // reset asserted during a response
    @(negedge clk);
    check("pre_rst_ready", 32'(bus_ready), 32'd1);
    bus_valid = 1'b1; bus_we = 1'b0; bus_addr = ADDR_EN;
    @(posedge clk);
    @(negedge clk);
    bus_valid = 1'b0;
    check("pre_rst_rvalid", 32'(bus_rvalid), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_drop_rvalid", 32'(bus_rvalid), 32'd0);
    check("rst_drop_ready", 32'(bus_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_rvalid_after_rst", 32'(bus_rvalid), 32'd0);
    end
    check("en_after_rst", 32'(gpio_en), 32'd0);
    check("ready_after_rst", 32'(bus_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
- Bus-facing control and status stage that sits directly upstream of the GPIO pin block.
- Holds the enable, direction and output-data registers that drive that block.
- Samples the pin-input data it returns, synchronises it and raises a maskable edge interrupt.
- Gives the CPU a simple valid/ready register port with a one-cycle read response.

Parameters:
- WIDTH, 8: number of GPIO pins handled.
- SYNC_STAGES, 2: flops in the input synchroniser chain; minimum 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous reset, active-low; asserts immediately, deasserts synchronously in the system.
- bus_valid  input  1  request present.
- bus_ready  output  1  request accepted when bus_valid & bus_ready.
- bus_we  input  1  1 = write, 0 = read.
- bus_addr  input  3  register index.
- bus_wdata  input  WIDTH  write data.
- bus_rvalid  output  1  response cycle; read data valid, write acknowledged.
- bus_rdata  output  WIDTH  read data; 0 when bus_rvalid=0.
- gpio_en  output  WIDTH  per-pin enable to the pin block.
- gpio_dir  output  WIDTH  per-pin direction, 1 = input.
- gpio_out  output  WIDTH  output data to the pin block.
- gpio_in  input  WIDTH  raw pin-input data from the pin block; asynchronous.
- irq  output  1  level interrupt.

Behaviour:
- Reset (rst=0): all registers 0, FSM to IDLE, bus_ready=0 for the reset duration, bus_rvalid=0, bus_rdata=0, irq=0, synchroniser flops 0.
- Register map, by bus_addr:
  - 0 EN (RW)
  - 1 DIR (RW)
  - 2 OUT (RW)
  - 3 IN (RO, synchronised value)
  - 4 IE_MASK (RW)
  - 5 EDGE (RW; 1 = rising, 0 = falling)
  - 6 STATUS (RO read, W1C write)
  - 7 reserved: reads 0, writes ignored, still acknowledged.
- FSM has two states:
  - IDLE: bus_ready=1. An accepted request moves to RESP.
  - RESP: bus_ready=0, bus_rvalid=1, bus_rdata holds the registered read value (0 for writes). Always returns to IDLE next cycle.
  - Throughput is therefore one transaction per 2 cycles, and read latency is 1 cycle after acceptance.
- Write effect: the register updates on the accepting edge and is visible on the gpio_* outputs the cycle after acceptance.
- Read value: captured at acceptance. A read of IN returns the synchroniser output at that edge.
- Synchroniser: gpio_in passes through SYNC_STAGES flops to give sync. A further flop gives sync_d.
- Edge detect, per pin i:
  - rise = sync[i] & ~sync_d[i]; fall = ~sync[i] & sync_d[i].
  - evt[i] = EN[i] & DIR[i] & (EDGE[i] ? rise : fall).
  - Pins that are disabled or set as outputs never set STATUS.
- STATUS update: STATUS <= (STATUS & ~w1c_mask) | evt.
  - w1c_mask = bus_wdata on an accepted write to addr 6, else 0.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- irq is registered: irq <= |(STATUS & IE_MASK). It lags a STATUS change by 1 cycle.
- Reconfiguration: changing DIR/EN/EDGE does not clear STATUS. A pin enabled while its synced input is already high raises no event; only a genuine transition does.
- Reset asserted mid-transaction: the response is dropped and no bus_rvalid follows reset release.
- bus_valid held high in RESP: not accepted until IDLE. The request must stay stable until accepted.

Decomposition:
- Shared package gpio_pkg holds:
  - Register index constants: ADDR_EN … ADDR_STATUS.
  - Default WIDTH.
  - FSM state enum: ST_IDLE, ST_RESP.
- Natural sub-module: gpio_sync_edge. It contains the per-pin synchroniser chain, the sync_d flop and the rise/fall outputs, parameterised by WIDTH and SYNC_STAGES.
- The register file and FSM stay in gpio_ctrl.

Test Plan:
- Reset values: hold rst=0 for 3 cycles, then release → gpio_en/dir/out=0x00, irq=0, bus_rvalid=0. In the first cycle after release, bus_ready=1.
- Register access: write EN=0xF0, DIR=0x0F, OUT=0xA5, then read each back.
  - Each read returns the written value on bus_rvalid, 1 cycle after acceptance.
  - gpio_out=0xA5 on the cycle after the write is accepted.
  - bus_ready=0 during every RESP cycle.
- Input synchronisation: EN=0xFF, DIR=0xFF; drive gpio_in=0x3C → a read of IN returns 0x3C only once ≥2 cycles have elapsed after the change. A read earlier than that returns 0x00.
- Rising-edge interrupt: IE_MASK=0x01, EDGE=0x01, EN=DIR=0x01; drive gpio_in[0] 0→1.
  - STATUS=0x01 at SYNC_STAGES+1 cycles after the change.
  - irq=1 one cycle later.
  - Write STATUS=0x01 → irq=0 two cycles after acceptance.
- Masking and direction: EDGE=0x00 (falling) on pin 1, with DIR[1]=0 → a 1→0 on gpio_in[1] leaves STATUS=0. With DIR[1]=1 the same edge gives STATUS[1]=1, but with IE_MASK[1]=0 irq stays 0.
- Set-vs-clear collision and reserved address:
  - Time a W1C of bit 0 to land on the same cycle as a new rising event on pin 0 → STATUS[0] remains 1.
  - Read addr 7 → 0x00.
  - Assert rst during RESP → no bus_rvalid after release.
